// File: rtl/cpl_tlp_tx.sv
// Completer TX: turns each AXI-Lite read response plus its popped tag entry into a 3DW CplD on a 64-bit AXI-Stream.
// Define CPL_UR_EN to also send 3DW Cpl (no data, status UR) on ur_valid.
module cpl_tlp_tx #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          completer_id,
    input  logic                 rd_valid,
    input  logic [31:0]          rd_data,
    output logic                 rd_ready,
    output logic                 tag_mang_read_en,
    input  logic [2:0]           tag_mang_tc_rd,
    input  logic [2:0]           tag_mang_attr_rd,
    input  logic [15:0]          tag_mang_requester_id_rd,
    input  logic [6:0]           tag_mang_lower_addr_rd,
    input  logic                 tag_mang_completer_func_rd,
    input  logic [7:0]           tag_mang_tag_rd,
    input  logic [3:0]           tag_mang_first_be_rd,
    output logic [63:0]          s_axis_tx_tdata,
    output logic [7:0]           s_axis_tx_tkeep,
    output logic                 s_axis_tx_tlast,
    output logic                 s_axis_tx_tvalid,
    input  logic                 s_axis_tx_tready,
    input  logic                 ur_valid,
    output logic                 ur_ready,
    output logic [CNT_WIDTH-1:0] cpl_count
);
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2} state_t;

    state_t      state, state_nxt;
    logic        accept_rd, accept_ur, accept;
    logic        unused_bits;
    logic [2:0]  tc_q;
    logic [1:0]  attr_q;
    logic [15:0] rid_q;
    logic [4:0]  la_q;
    logic [7:0]  tag_q;
    logic [3:0]  be_q;
    logic [31:0] data_q;
    logic        ur_q;
    logic [63:0] tdata_nxt;
    logic [7:0]  tkeep_nxt;
    logic        tlast_nxt, tvalid_nxt;

    function automatic logic [11:0] byte_count(input logic [3:0] be);
        casez (be)
            4'b1??1:                   return 12'd4;
            4'b01?1, 4'b1?10:          return 12'd3;
            4'b0011, 4'b0110, 4'b1100: return 12'd2;
            default:                   return 12'd1;
        endcase
    endfunction

    function automatic logic [1:0] low_addr10(input logic [3:0] be);
        if (be[0])      return 2'd0;
        else if (be[1]) return 2'd1;
        else if (be[2]) return 2'd2;
        else if (be[3]) return 2'd3;
        else            return 2'd0;
    endfunction

    function automatic logic [31:0] dw0(input logic ur, input logic [2:0] tc, input logic [1:0] attr);
        return {1'b0, (ur ? 2'b00 : 2'b10), 5'b01010, 1'b0, tc, 4'b0000, 1'b0, 1'b0, attr, 2'b00,
                (ur ? 10'd0 : 10'd1)};
    endfunction

    function automatic logic [31:0] dw1(input logic [14:0] cid_hi, input logic func, input logic ur,
                                        input logic [3:0] be);
        return {cid_hi, func, (ur ? 3'b001 : 3'b000), 1'b0, (ur ? 12'd4 : byte_count(be))};
    endfunction

    function automatic logic [31:0] dw2(input logic [15:0] rid, input logic [7:0] tag, input logic [4:0] la_hi,
                                        input logic [3:0] be);
        return {rid, tag, 1'b0, la_hi, low_addr10(be)};
    endfunction

    // Gated by reset so nothing is popped from the tag store while held in reset.
    assign rd_ready         = !reset && ((state == IDLE) || (state == DATA && s_axis_tx_tready));
    assign accept_rd        = rd_valid && rd_ready;
    assign accept           = accept_rd || accept_ur;
    assign tag_mang_read_en = accept;

`ifdef CPL_UR_EN
    assign ur_ready    = rd_ready && !rd_valid;
    assign accept_ur   = ur_valid && ur_ready;
    assign unused_bits = ^{completer_id[0], tag_mang_attr_rd[2], tag_mang_lower_addr_rd[1:0]};
`else
    assign ur_ready    = 1'b0;
    assign accept_ur   = 1'b0;
    assign unused_bits = ^{ur_valid, completer_id[0], tag_mang_attr_rd[2], tag_mang_lower_addr_rd[1:0]};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = HDR;
            HDR:     if (s_axis_tx_tready) state_nxt = DATA;
            DATA:    if (s_axis_tx_tready) state_nxt = accept ? HDR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next beat: header straight from the tag outputs on accept, DW2+payload from captured fields after HDR.
    always_comb begin
        tdata_nxt  = s_axis_tx_tdata;
        tkeep_nxt  = s_axis_tx_tkeep;
        tlast_nxt  = s_axis_tx_tlast;
        tvalid_nxt = s_axis_tx_tvalid;
        if (accept) begin
            tdata_nxt  = {dw1(completer_id[15:1], tag_mang_completer_func_rd, accept_ur, tag_mang_first_be_rd),
                          dw0(accept_ur, tag_mang_tc_rd, tag_mang_attr_rd[1:0])};
            tkeep_nxt  = 8'hFF;
            tlast_nxt  = 1'b0;
            tvalid_nxt = 1'b1;
        end else if (state == HDR && s_axis_tx_tready) begin
            tdata_nxt  = {(ur_q ? 32'h0 : data_q), dw2(rid_q, tag_q, la_q, be_q)};
            tkeep_nxt  = ur_q ? 8'h0F : 8'hFF;
            tlast_nxt  = 1'b1;
        end else if (state == DATA && s_axis_tx_tready) begin
            tlast_nxt  = 1'b0;
            tvalid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_axis_tx_tdata  <= '0;
            s_axis_tx_tkeep  <= '0;
            s_axis_tx_tlast  <= 1'b0;
            s_axis_tx_tvalid <= 1'b0;
        end else begin
            s_axis_tx_tdata  <= tdata_nxt;
            s_axis_tx_tkeep  <= tkeep_nxt;
            s_axis_tx_tlast  <= tlast_nxt;
            s_axis_tx_tvalid <= tvalid_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tc_q   <= '0;
            attr_q <= '0;
            rid_q  <= '0;
            la_q   <= '0;
            tag_q  <= '0;
            be_q   <= '0;
            data_q <= '0;
            ur_q   <= 1'b0;
        end else if (accept) begin
            tc_q   <= tag_mang_tc_rd;
            attr_q <= tag_mang_attr_rd[1:0];
            rid_q  <= tag_mang_requester_id_rd;
            la_q   <= tag_mang_lower_addr_rd[6:2];
            tag_q  <= tag_mang_tag_rd;
            be_q   <= tag_mang_first_be_rd;
            data_q <= rd_data;
            ur_q   <= accept_ur;
        end
    end

    // attr_q is only needed at accept time today, but keeps the captured entry complete.
    logic unused_attr;
    assign unused_attr = ^{attr_q, tc_q, unused_bits};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                  cpl_count <= '0;
        else if (state == DATA && s_axis_tx_tready) cpl_count <= cpl_count + CNT_WIDTH'(1);
    end
endmodule

// File: tb/tb_cpl_tlp_tx.sv
// Randomized self-checking bench for cpl_tlp_tx against a header-arithmetic reference model.
`timescale 1ns/1ps
module tb_cpl_tlp_tx;
    localparam int unsigned CW = 16;

    typedef struct {
        logic [2:0]  tc;
        logic [2:0]  attr;
        logic [15:0] rid;
        logic [6:0]  la;
        logic        func;
        logic [7:0]  tag;
        logic [3:0]  be;
        logic [31:0] data;
        logic        ur;
    } ent_t;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [31:0] cyc;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   completer_id;
    logic          rd_valid;
    logic [31:0]   rd_data;
    logic          rd_ready;
    logic          tag_mang_read_en;
    logic [2:0]    tag_mang_tc_rd;
    logic [2:0]    tag_mang_attr_rd;
    logic [15:0]   tag_mang_requester_id_rd;
    logic [6:0]    tag_mang_lower_addr_rd;
    logic          tag_mang_completer_func_rd;
    logic [7:0]    tag_mang_tag_rd;
    logic [3:0]    tag_mang_first_be_rd;
    logic [63:0]   s_axis_tx_tdata;
    logic [7:0]    s_axis_tx_tkeep;
    logic          s_axis_tx_tlast;
    logic          s_axis_tx_tvalid;
    logic          s_axis_tx_tready;
    logic          ur_valid;
    logic          ur_ready;
    logic [CW-1:0] cpl_count;
    logic          man_rdy, rand_rdy_en, rnd_rdy;

    cpl_tlp_tx #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .completer_id(completer_id),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .tag_mang_read_en(tag_mang_read_en), .tag_mang_tc_rd(tag_mang_tc_rd),
        .tag_mang_attr_rd(tag_mang_attr_rd), .tag_mang_requester_id_rd(tag_mang_requester_id_rd),
        .tag_mang_lower_addr_rd(tag_mang_lower_addr_rd), .tag_mang_completer_func_rd(tag_mang_completer_func_rd),
        .tag_mang_tag_rd(tag_mang_tag_rd), .tag_mang_first_be_rd(tag_mang_first_be_rd),
        .s_axis_tx_tdata(s_axis_tx_tdata), .s_axis_tx_tkeep(s_axis_tx_tkeep),
        .s_axis_tx_tlast(s_axis_tx_tlast), .s_axis_tx_tvalid(s_axis_tx_tvalid),
        .s_axis_tx_tready(s_axis_tx_tready), .ur_valid(ur_valid), .ur_ready(ur_ready),
        .cpl_count(cpl_count)
    );

    always #5 clk = ~clk;
    assign s_axis_tx_tready = rand_rdy_en ? rnd_rdy : man_rdy;

    int    tests = 0;
    int    fails = 0;
    int    bi = 0;
    int    ei = 0;
    int    cyc = 0;
    beat_t beat_q[$];
    beat_t exp_q[$];
    int    pop_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        rnd_rdy = ($urandom_range(3) != 0);
    end

    // Passive monitor: every accepted beat and every tag-store pop, tagged with its cycle.
    always @(negedge clk) begin
        if (!reset && s_axis_tx_tvalid && s_axis_tx_tready)
            beat_q.push_back('{data: s_axis_tx_tdata, keep: s_axis_tx_tkeep,
                               last: s_axis_tx_tlast, cyc: 32'(cyc)});
        if (tag_mang_read_en) pop_cyc.push_back(cyc);
    end

    // Reference: header fields laid out by bit position; byte count is the span of enabled bytes.
    function automatic void model_push(input ent_t e);
        int lo, hi, bc;
        logic [31:0] d0, d1, d2;
        lo = 0; hi = 0; bc = 1;
        if (e.be != 4'b0000) begin
            lo = -1;
            for (int i = 0; i < 4; i++) if (e.be[i]) begin
                if (lo < 0) lo = i;
                hi = i;
            end
            bc = hi - lo + 1;
        end
        if (e.ur) bc = 4;
        d0 = (e.ur ? 32'h0 : (32'd2 << 29)) | (32'd10 << 24) | (32'(e.tc) << 20)
           | (32'(e.attr[1:0]) << 12) | (e.ur ? 32'd0 : 32'd1);
        d1 = (32'(completer_id >> 1) << 17) | (32'(e.func) << 16) | (e.ur ? (32'd1 << 13) : 32'd0) | 32'(bc);
        d2 = (32'(e.rid) << 16) | (32'(e.tag) << 8) | (32'(e.la) & 32'h7C) | 32'(lo);
        exp_q.push_back('{data: {d1, d0}, keep: 8'hFF, last: 1'b0, cyc: 32'd0});
        exp_q.push_back('{data: {(e.ur ? 32'h0 : e.data), d2}, keep: (e.ur ? 8'h0F : 8'hFF),
                          last: 1'b1, cyc: 32'd0});
    endfunction

    function automatic ent_t rand_ent();
        ent_t e;
        e.tc = 3'($urandom); e.attr = 3'($urandom); e.rid = 16'($urandom); e.la = 7'($urandom);
        e.func = 1'($urandom); e.tag = 8'($urandom); e.be = 4'($urandom); e.data = $urandom; e.ur = 1'b0;
        return e;
    endfunction

    task automatic drive_ent(input ent_t e);
        tag_mang_tc_rd = e.tc; tag_mang_attr_rd = e.attr; tag_mang_requester_id_rd = e.rid;
        tag_mang_lower_addr_rd = e.la; tag_mang_completer_func_rd = e.func; tag_mang_tag_rd = e.tag;
        tag_mang_first_be_rd = e.be; rd_data = e.data;
    endtask

    // Returns just after the edge on which rd_ready was seen high.
    task automatic wait_rd(input string nm);
        bit ok = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            if (rd_ready) ok = 1;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL %s: rd_ready timeout, got 0 required 1", nm);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_rd(input ent_t e, input string nm);
        @(posedge clk); #1;
        drive_ent(e);
        rd_valid = 1'b1;
        wait_rd(nm);
        rd_valid = 1'b0;
        model_push(e);
    endtask

    task automatic wait_beats(input int n, input string nm);
        for (int k = 0; k < 400 && beat_q.size() < n; k++) @(negedge clk);
        if (beat_q.size() < n) begin
            tests++; fails++;
            $display("FAIL %s: beat timeout, got %0d beats required %0d", nm, beat_q.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; rd_valid = 1'b0; ur_valid = 1'b0; man_rdy = 1'b1; rand_rdy_en = 1'b0;
        completer_id = 16'h0200; rd_data = '0;
        tag_mang_tc_rd = '0; tag_mang_attr_rd = '0; tag_mang_requester_id_rd = '0; tag_mang_lower_addr_rd = '0;
        tag_mang_completer_func_rd = 1'b0; tag_mang_tag_rd = '0; tag_mang_first_be_rd = '0;
        #22;
        tests++; if (s_axis_tx_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b required 0", s_axis_tx_tvalid); end
        tests++; if (s_axis_tx_tlast !== 1'b0) begin fails++; $display("FAIL reset_tlast: got %b required 0", s_axis_tx_tlast); end
        tests++; if (s_axis_tx_tdata !== 64'h0) begin fails++; $display("FAIL reset_tdata: got %h required 0", s_axis_tx_tdata); end
        tests++; if (cpl_count !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d required 0", cpl_count); end
        tests++; if (tag_mang_read_en !== 1'b0) begin fails++; $display("FAIL reset_read_en: got %b required 0", tag_mang_read_en); end
        tests++; if (ur_ready !== 1'b0) begin fails++; $display("FAIL reset_ur_ready: got %b required 0", ur_ready); end
        @(posedge clk); #1 reset = 1'b0;
        #1;
        tests++; if (rd_ready !== 1'b1) begin fails++; $display("FAIL reset_rd_ready: got %b required 1", rd_ready); end
    endtask

    task automatic test_basic();
        ent_t e;
        int nb, np;
        nb = beat_q.size(); np = pop_cyc.size();
        e = '{tc: 3'd0, attr: 3'd0, rid: 16'h0100, la: 7'h24, func: 1'b0, tag: 8'h05, be: 4'hF,
              data: 32'hDEADBEEF, ur: 1'b0};
        send_rd(e, "basic");
        wait_beats(nb + 2, "basic");
        repeat (2) @(posedge clk);
        #1;
        if (beat_q.size() >= nb + 2 && pop_cyc.size() >= np + 1) begin
            tests++; if (beat_q[nb].data !== 64'h0200_0004_4A00_0001 || beat_q[nb].last !== 1'b0) begin
                fails++; $display("FAIL basic_beat0: got %h last %b required 020000044a000001 last 0", beat_q[nb].data, beat_q[nb].last); end
            tests++; if (beat_q[nb+1].data !== 64'hDEADBEEF_0100_0524 || beat_q[nb+1].last !== 1'b1) begin
                fails++; $display("FAIL basic_beat1: got %h last %b required deadbeef01000524 last 1", beat_q[nb+1].data, beat_q[nb+1].last); end
            tests++; if (beat_q[nb].cyc !== 32'(pop_cyc[np] + 1)) begin
                fails++; $display("FAIL basic_latency: got cycle %0d required %0d", beat_q[nb].cyc, pop_cyc[np] + 1); end
        end
        tests++; if (pop_cyc.size() !== np + 1) begin fails++; $display("FAIL basic_pops: got %0d required %0d", pop_cyc.size() - np, 1); end
        tests++; if (cpl_count !== 16'd1) begin fails++; $display("FAIL basic_count: got %0d required 1", cpl_count); end
        bi = beat_q.size(); ei = exp_q.size();
    endtask

    task automatic test_be_sweep();
        logic [3:0]  be_v [5] = '{4'b0001, 4'b0110, 4'b1000, 4'b0000, 4'b1001};
        logic [11:0] bc_v [5] = '{12'd1, 12'd2, 12'd1, 12'd1, 12'd4};
        logic [1:0]  la_v [5] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd0};
        for (int i = 0; i < 5; i++) begin
            ent_t e;
            int nb;
            nb = beat_q.size();
            e = rand_ent(); e.be = be_v[i];
            send_rd(e, "be_sweep");
            wait_beats(nb + 2, "be_sweep");
            if (beat_q.size() >= nb + 2) begin
                tests++; if (beat_q[nb].data[43:32] !== bc_v[i]) begin
                    fails++; $display("FAIL be_sweep_bc be=%b: got %0d required %0d", be_v[i], beat_q[nb].data[43:32], bc_v[i]); end
                tests++; if (beat_q[nb+1].data[1:0] !== la_v[i]) begin
                    fails++; $display("FAIL be_sweep_la10 be=%b: got %b required %b", be_v[i], beat_q[nb+1].data[1:0], la_v[i]); end
            end
        end
        while (bi < beat_q.size() && ei < exp_q.size()) begin
            tests++;
            if (beat_q[bi].data !== exp_q[ei].data || beat_q[bi].keep !== exp_q[ei].keep || beat_q[bi].last !== exp_q[ei].last) begin
                fails++; $display("FAIL be_sweep_beat %0d: got %h/%h/%b required %h/%h/%b", bi, beat_q[bi].data,
                    beat_q[bi].keep, beat_q[bi].last, exp_q[ei].data, exp_q[ei].keep, exp_q[ei].last); end
            bi++; ei++;
        end
    endtask

    task automatic test_stall();
        ent_t e1, e2;
        int np;
        logic [63:0] held;
        man_rdy = 1'b0;
        e1 = rand_ent(); e2 = rand_ent();
        send_rd(e1, "stall");
        np = pop_cyc.size();
        drive_ent(e2); rd_valid = 1'b1;
        @(negedge clk);
        held = s_axis_tx_tdata;
        repeat (5) begin
            @(negedge clk);
            tests++; if (s_axis_tx_tvalid !== 1'b1 || s_axis_tx_tdata !== held) begin
                fails++; $display("FAIL stall_hold: got %b/%h required 1/%h", s_axis_tx_tvalid, s_axis_tx_tdata, held); end
            tests++; if (rd_ready !== 1'b0 || tag_mang_read_en !== 1'b0) begin
                fails++; $display("FAIL stall_no_pop: got rd_ready %b read_en %b required 0 0", rd_ready, tag_mang_read_en); end
        end
        @(posedge clk); #1 man_rdy = 1'b1;
        wait_rd("stall_second");
        rd_valid = 1'b0;
        model_push(e2);
        wait_beats(bi + 4, "stall");
        tests++; if (pop_cyc.size() !== np + 1) begin fails++; $display("FAIL stall_pops: got %0d required 1", pop_cyc.size() - np); end
        while (bi < beat_q.size() && ei < exp_q.size()) begin
            tests++;
            if (beat_q[bi].data !== exp_q[ei].data || beat_q[bi].keep !== exp_q[ei].keep || beat_q[bi].last !== exp_q[ei].last) begin
                fails++; $display("FAIL stall_beat %0d: got %h/%h/%b required %h/%h/%b", bi, beat_q[bi].data,
                    beat_q[bi].keep, beat_q[bi].last, exp_q[ei].data, exp_q[ei].keep, exp_q[ei].last); end
            bi++; ei++;
        end
    endtask

    task automatic test_back_to_back();
        ent_t e1, e2;
        int nb, np;
        logic [CW-1:0] c0;
        man_rdy = 1'b1;
        e1 = rand_ent(); e2 = rand_ent();
        repeat (2) @(posedge clk);
        #1;
        nb = beat_q.size(); np = pop_cyc.size(); c0 = cpl_count;
        drive_ent(e1); rd_valid = 1'b1;
        wait_rd("b2b_first");
        drive_ent(e2);
        wait_rd("b2b_second");
        rd_valid = 1'b0;
        model_push(e1); model_push(e2);
        wait_beats(nb + 4, "b2b");
        @(posedge clk); #1;
        if (pop_cyc.size() >= np + 2 && beat_q.size() >= nb + 4) begin
            tests++; if (pop_cyc[np+1] - pop_cyc[np] !== 2) begin
                fails++; $display("FAIL b2b_pop_spacing: got %0d required 2", pop_cyc[np+1] - pop_cyc[np]); end
            tests++; if (beat_q[nb+3].cyc - beat_q[nb].cyc !== 32'd3) begin
                fails++; $display("FAIL b2b_beat_span: got %0d required 3", beat_q[nb+3].cyc - beat_q[nb].cyc); end
        end
        tests++; if (cpl_count !== CW'(c0 + 2)) begin fails++; $display("FAIL b2b_count: got %0d required %0d", cpl_count, CW'(c0 + 2)); end
        while (bi < beat_q.size() && ei < exp_q.size()) begin
            tests++;
            if (beat_q[bi].data !== exp_q[ei].data || beat_q[bi].keep !== exp_q[ei].keep || beat_q[bi].last !== exp_q[ei].last) begin
                fails++; $display("FAIL b2b_beat %0d: got %h/%h/%b required %h/%h/%b", bi, beat_q[bi].data,
                    beat_q[bi].keep, beat_q[bi].last, exp_q[ei].data, exp_q[ei].keep, exp_q[ei].last); end
            bi++; ei++;
        end
    endtask

    task automatic test_random();
        logic [CW-1:0] c0;
        c0 = cpl_count;
        completer_id = 16'hA5C3;
        rand_rdy_en = 1'b1;
        for (int i = 0; i < 24; i++) send_rd(rand_ent(), "random");
        wait_beats(bi + 48, "random");
        rand_rdy_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (cpl_count !== CW'(c0 + 24)) begin fails++; $display("FAIL random_count: got %0d required %0d", cpl_count, CW'(c0 + 24)); end
        while (bi < beat_q.size() && ei < exp_q.size()) begin
            tests++;
            if (beat_q[bi].data !== exp_q[ei].data || beat_q[bi].keep !== exp_q[ei].keep || beat_q[bi].last !== exp_q[ei].last) begin
                fails++; $display("FAIL random_beat %0d: got %h/%h/%b required %h/%h/%b", bi, beat_q[bi].data,
                    beat_q[bi].keep, beat_q[bi].last, exp_q[ei].data, exp_q[ei].keep, exp_q[ei].last); end
            bi++; ei++;
        end
        completer_id = 16'h0200;
    endtask

    task automatic test_reset_mid();
        man_rdy = 1'b0;
        send_rd(rand_ent(), "reset_mid");
        man_rdy = 1'b1;
        @(posedge clk); #1 man_rdy = 1'b0;
        tests++; if (s_axis_tx_tvalid !== 1'b1 || s_axis_tx_tlast !== 1'b1) begin
            fails++; $display("FAIL reset_mid_in_data: got tvalid %b tlast %b required 1 1", s_axis_tx_tvalid, s_axis_tx_tlast); end
        #2 reset = 1'b1;
        #1;
        tests++; if (s_axis_tx_tvalid !== 1'b0) begin fails++; $display("FAIL reset_mid_tvalid: got %b required 0", s_axis_tx_tvalid); end
        tests++; if (cpl_count !== 16'd0) begin fails++; $display("FAIL reset_mid_count: got %0d required 0", cpl_count); end
        @(posedge clk); #1 reset = 1'b0; man_rdy = 1'b1;
        bi = beat_q.size(); ei = exp_q.size();
        send_rd(rand_ent(), "reset_mid_fresh");
        wait_beats(bi + 2, "reset_mid_fresh");
        @(posedge clk); #1;
        if (beat_q.size() > bi) begin
            tests++; if (beat_q[bi].last !== 1'b0) begin fails++; $display("FAIL reset_mid_fresh_hdr: got last %b required 0", beat_q[bi].last); end
        end
        tests++; if (cpl_count !== 16'd1) begin fails++; $display("FAIL reset_mid_fresh_count: got %0d required 1", cpl_count); end
        while (bi < beat_q.size() && ei < exp_q.size()) begin
            tests++;
            if (beat_q[bi].data !== exp_q[ei].data || beat_q[bi].keep !== exp_q[ei].keep || beat_q[bi].last !== exp_q[ei].last) begin
                fails++; $display("FAIL reset_mid_beat %0d: got %h/%h/%b required %h/%h/%b", bi, beat_q[bi].data,
                    beat_q[bi].keep, beat_q[bi].last, exp_q[ei].data, exp_q[ei].keep, exp_q[ei].last); end
            bi++; ei++;
        end
    endtask

`ifdef CPL_UR_EN
    task automatic test_ur();
        ent_t a, u;
        int nb;
        bit ok;
        man_rdy = 1'b1;
        a = rand_ent(); u = rand_ent(); u.tag = 8'h07; u.ur = 1'b1;
        @(posedge clk); #1;
        nb = beat_q.size();
        drive_ent(a); rd_valid = 1'b1; ur_valid = 1'b1;
        #1;
        tests++; if (ur_ready !== 1'b0) begin fails++; $display("FAIL ur_priority: got ur_ready %b required 0", ur_ready); end
        wait_rd("ur_rd_first");
        rd_valid = 1'b0;
        model_push(a);
        drive_ent(u);
        ok = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (ur_ready) ok = 1;
        end
        tests++; if (!ok) begin fails++; $display("FAIL ur_ready_timeout: got 0 required 1"); end
        @(posedge clk); #1 ur_valid = 1'b0;
        model_push(u);
        wait_beats(nb + 4, "ur");
        if (beat_q.size() >= nb + 4) begin
            tests++; if (beat_q[nb+1].data[63:32] !== a.data) begin
                fails++; $display("FAIL ur_rd_first_payload: got %h required %h", beat_q[nb+1].data[63:32], a.data); end
            tests++; if (beat_q[nb+2].data[47:45] !== 3'b001 || beat_q[nb+2].data[9:0] !== 10'd0) begin
                fails++; $display("FAIL ur_status_len: got %b/%0d required 001/0", beat_q[nb+2].data[47:45], beat_q[nb+2].data[9:0]); end
            tests++; if (beat_q[nb+3].keep !== 8'h0F || beat_q[nb+3].data[15:8] !== 8'h07) begin
                fails++; $display("FAIL ur_beat1: got keep %h tag %h required 0f 07", beat_q[nb+3].keep, beat_q[nb+3].data[15:8]); end
        end
        while (bi < beat_q.size() && ei < exp_q.size()) begin
            logic [63:0] m;
            m = '0;
            for (int k = 0; k < 8; k++) if (exp_q[ei].keep[k]) m[k*8 +: 8] = 8'hFF;
            tests++;
            if ((beat_q[bi].data & m) !== (exp_q[ei].data & m) || beat_q[bi].keep !== exp_q[ei].keep || beat_q[bi].last !== exp_q[ei].last) begin
                fails++; $display("FAIL ur_beat %0d: got %h/%h/%b required %h/%h/%b", bi, beat_q[bi].data,
                    beat_q[bi].keep, beat_q[bi].last, exp_q[ei].data, exp_q[ei].keep, exp_q[ei].last); end
            bi++; ei++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_be_sweep();
        test_stall();
        test_back_to_back();
        test_random();
`ifdef CPL_UR_EN
        test_ur();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
